rx: RTL and testbench

- Serial receiver for the single-wire, clock-synchronous router link; far end of the per-port serial transmitter.
- Detects a frame's start bit, deserialises a flit of `SIZE data bits (LSB first) into a small output FIFO and presents it to the router with a valid/ack handshake.
- Drives channel_busy back to the transmitter for flow control: the sender never starts a frame while channel_busy is high.

---
 rtl/rx_pkg.sv | 19 +
 rtl/rx_fifo.sv | 63 ++++++
 rtl/rx.sv | 100 ++++++++++
 tb/tb_rx.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and widths for the serial link receiver.
`ifndef SIZE
`define SIZE 8
`endif

package rx_pkg;

  // Flit width on the link and the width of the bit counter.
  localparam int FLIT_W = `SIZE;
  localparam int CNT_W  = $clog2(`SIZE) + 1;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO; head entry is visible combinationally, 0 when empty.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH explicitly so a depth of one stays at slot 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the same edge frees the head.
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rx.sv
// Serial link receiver: start-bit detect, LSB-first deserialise, FIFO and flow control.
module rx
  import rx_pkg::*;
#(
  parameter int    DEPTH    = 2,
  parameter int    routerid = -1,
  parameter string port     = "unknown"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic              channel_busy,
  output logic [FLIT_W-1:0] parallel_out,
  output logic              valid,
  input  logic              ack,
  output logic              rx_active,
  output logic              overflow
);

  rx_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  flit_t            shift_reg, shift_next;
  logic             drop_reg, drop_next;
  logic             ovf_reg, ovf_next;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [$clog2(DEPTH+1)-1:0] count_unused;
  logic             unused_dbg;

  // Debug identity is kept for simulation builds only; it drives no logic.
  assign unused_dbg = (routerid > -1) && (port != "");

  // State, counter, shift register and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      drop_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      drop_reg  <= drop_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Frame FSM: a frame started while the FIFO is full is clocked through but not stored.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    drop_next  = drop_reg;
    ovf_next   = ovf_reg;
    push       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (serial_in) begin
          state_next = RECV;
          cnt_next   = '0;
          drop_next  = fifo_full;
          if (fifo_full) ovf_next = 1'b1;
        end
      end
      RECV: begin
        shift_next = {serial_in, shift_reg[FLIT_W-1:1]};
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(FLIT_W - 1)) begin
          state_next = IDLE;
          push       = !drop_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  rx_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shift_next),
    .pop   (ack),
    .dout  (parallel_out),
    .count (count_unused),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_active    = (state_reg == RECV);
  assign valid        = !fifo_empty;
  assign overflow     = ovf_reg;
  assign channel_busy = rx_active | fifo_full;

endmodule

// File: tb/tb_rx.sv
// Randomised self-checking bench for rx against a queue-based link model.
`ifndef SIZE
`define SIZE 8
`endif

module tb_rx;

  localparam int DEPTH = 2;
  localparam int W     = `SIZE;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         serial_in = 1'b0;
  logic         ack = 1'b0;
  logic         channel_busy;
  logic [W-1:0] parallel_out;
  logic         valid;
  logic         rx_active;
  logic         overflow;

  rx #(.DEPTH(DEPTH), .routerid(-1), .port("tb")) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .channel_busy (channel_busy),
    .parallel_out (parallel_out),
    .valid        (valid),
    .ack          (ack),
    .rx_active    (rx_active),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stored flits, sticky error, frame-in-progress, drop decision.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rcv[$];
  bit model_ovf = 0;
  bit model_drop = 0;
  bit model_in_frame = 0;
  bit rand_ack = 0;

  // One clock: record a pop, advance the model by the link rules, sample #1 after the edge.
  task automatic step(input bit start_b, input bit done_b, input logic [W-1:0] d);
    int sz;
    if (rand_ack) ack = 1'($urandom_range(0, 1));
    if (ack && valid) begin
      rcv.push_back(parallel_out);
      $display("pop flit %0h", parallel_out);
    end
    sz = exp_q.size();
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      model_ovf = 0;
      model_drop = 0;
      model_in_frame = 0;
    end else begin
      if (ack && sz > 0) void'(exp_q.pop_front());
      if (start_b) begin
        model_drop = (sz == DEPTH);
        if (model_drop) model_ovf = 1;
        model_in_frame = 1;
      end
      if (done_b) begin
        model_in_frame = 0;
        if (!model_drop) exp_q.push_back(d);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b0;
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  task automatic tx_frame(input logic [W-1:0] d);
    serial_in = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < W; i++) begin
      serial_in = d[i];
      step(1'b0, i == W - 1, d);
    end
    serial_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ack = 1'b0;
    idle(2);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      idle(1);
      n_cmp++;
      if ({channel_busy, valid, rx_active, overflow} !== 4'b0000 || parallel_out !== '0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: busy=%b valid=%b act=%b ovf=%b out=%h, required all 0",
                 c, channel_busy, valid, rx_active, overflow, parallel_out);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [W-1:0] d;
    d = W'(8'hA5);
    rcv.delete();
    idle(3);
    serial_in = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < W; i++) begin
      n_cmp++;
      if (rx_active !== 1'b1 || valid !== 1'b0) begin
        n_err++;
        $display("FAIL single_active bit %0d: act=%b valid=%b, required act=1 valid=0", i, rx_active, valid);
      end
      serial_in = d[i];
      step(1'b0, i == W - 1, d);
    end
    serial_in = 1'b0;
    n_cmp++;
    if (rx_active !== 1'b0 || valid !== 1'b1 || parallel_out !== d || channel_busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: act=%b valid=%b out=%h busy=%b, required 0 1 %h 0",
               rx_active, valid, parallel_out, channel_busy, d);
    end
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || parallel_out !== '0 || rcv.size() != 1 || rcv[0] !== d) begin
      n_err++;
      $display("FAIL single_pop: valid=%b out=%h pops=%0d, required valid=0 out=0 one pop of %h",
               valid, parallel_out, rcv.size(), d);
    end
  endtask

  task automatic test_flow_control();
    logic [W-1:0] f[4];
    int t;
    f[0] = W'(8'h01); f[1] = W'(8'h80); f[2] = W'(8'hFF); f[3] = W'(8'h00);
    rcv.delete();
    ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t = 0;
      while (channel_busy && t < 40) begin idle(1); t++; end
      n_cmp++;
      if (t == 40) begin n_err++; $display("FAIL flow_wait%0d: busy stuck high, required release", k); end
      tx_frame(f[k]);
      idle(1);
    end
    n_cmp++;
    if (channel_busy !== 1'b1 || valid !== 1'b1 || parallel_out !== f[0]) begin
      n_err++;
      $display("FAIL flow_full: busy=%b valid=%b out=%h, required 1 1 %h", channel_busy, valid, parallel_out, f[0]);
    end
    t = 0;
    while (channel_busy && t < 20) begin idle(1); t++; end
    n_cmp++;
    if (t != 20 || parallel_out !== f[0]) begin
      n_err++;
      $display("FAIL flow_block: busy low after %0d cycles out=%h, required held 20 with out=%h", t, parallel_out, f[0]);
    end
    ack = 1'b1;
    for (int k = 2; k < 4; k++) begin
      t = 0;
      while (channel_busy && t < 40) begin idle(1); t++; end
      n_cmp++;
      if (t == 40) begin n_err++; $display("FAIL flow_release%0d: busy stuck high, required release", k); end
      tx_frame(f[k]);
      idle(1);
    end
    t = 0;
    while (valid && t < 40) begin idle(1); t++; end
    ack = 1'b0;
    n_cmp++;
    if (rcv.size() != 4) begin
      n_err++;
      $display("FAIL flow_count: got %0d flits, required 4", rcv.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (rcv[k] !== f[k]) begin
          n_err++;
          $display("FAIL flow_order%0d: got %h, required %h", k, rcv[k], f[k]);
        end
      end
    end
  endtask

  task automatic test_full_minus_one_ack();
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = W'($urandom);
    rcv.delete();
    ack = 1'b0;
    tx_frame(a);
    idle(1);
    serial_in = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < W; i++) begin
      serial_in = b[i];
      ack = (i == W - 1);
      step(1'b0, i == W - 1, b);
    end
    ack = 1'b0;
    serial_in = 1'b0;
    n_cmp++;
    if (valid !== 1'b1 || parallel_out !== b || channel_busy !== 1'b0 || rcv.size() != 1 || rcv[0] !== a) begin
      n_err++;
      $display("FAIL edge_push_pop: valid=%b out=%h busy=%b pops=%0d, required 1 %h 0 with one pop of %h",
               valid, parallel_out, channel_busy, rcv.size(), b, a);
    end
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || rcv.size() != 2 || rcv[1] !== b) begin
      n_err++;
      $display("FAIL edge_drain: valid=%b pops=%0d, required valid=0 second pop %h", valid, rcv.size(), b);
    end
  endtask

  task automatic test_random();
    localparam int N = 30;
    logic [W-1:0] sent[$];
    logic [W-1:0] cur;
    logic [W-1:0] head;
    int idx, bit_i, gap, cyc;
    bit s, dn;
    idx = 0; bit_i = -1; gap = 0; cyc = 0; cur = '0;
    rcv.delete();
    rand_ack = 1;
    while ((idx < N || bit_i >= 0 || exp_q.size() > 0) && cyc < 4000) begin
      s = 0;
      dn = 0;
      if (bit_i < 0) begin
        serial_in = 1'b0;
        if (gap > 0) gap--;
        else if (idx < N && !channel_busy) begin
          cur = W'($urandom);
          serial_in = 1'b1;
          s = 1;
          bit_i = 0;
        end
      end else begin
        serial_in = cur[bit_i];
        dn = (bit_i == W - 1);
        if (dn) begin
          sent.push_back(cur);
          idx++;
          bit_i = -1;
          gap = $urandom_range(1, 3);
        end else bit_i++;
      end
      step(s, dn, cur);
      cyc++;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      n_cmp++;
      if (valid !== (exp_q.size() > 0) || parallel_out !== head ||
          channel_busy !== (model_in_frame || exp_q.size() == DEPTH) || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL random_cycle %0d: valid=%b out=%h busy=%b ovf=%b, required %b %h %b 0",
                 cyc, valid, parallel_out, channel_busy, overflow, exp_q.size() > 0, head,
                 model_in_frame || exp_q.size() == DEPTH);
      end
    end
    rand_ack = 0;
    ack = 1'b0;
    serial_in = 1'b0;
    n_cmp++;
    if (cyc >= 4000 || rcv.size() != N) begin
      n_err++;
      $display("FAIL random_total: %0d flits in %0d cycles, required %0d within budget", rcv.size(), cyc, N);
    end else begin
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (rcv[k] !== sent[k]) begin
          n_err++;
          $display("FAIL random_order%0d: got %h, required %h", k, rcv[k], sent[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] a, b, c;
    a = W'($urandom); b = W'($urandom); c = ~a;
    rcv.delete();
    ack = 1'b0;
    tx_frame(a); idle(1);
    tx_frame(b); idle(1);
    tx_frame(c); idle(1);
    n_cmp++;
    if (overflow !== 1'b1 || model_ovf !== 1'b1 || channel_busy !== 1'b1 || parallel_out !== a) begin
      n_err++;
      $display("FAIL ovf_set: ovf=%b busy=%b out=%h, required 1 1 %h", overflow, channel_busy, parallel_out, a);
    end
    idle(5);
    ack = 1'b1;
    idle(2);
    ack = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1 || valid !== 1'b0 || rcv.size() != 2 || rcv[0] !== a || rcv[1] !== b) begin
      n_err++;
      $display("FAIL ovf_sticky: ovf=%b valid=%b pops=%0d, required ovf=1 valid=0 pops %h %h",
               overflow, valid, rcv.size(), a, b);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d, g;
    d = W'($urandom);
    g = W'(8'h3C);
    ack = 1'b0;
    serial_in = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      step(1'b0, 1'b0, d);
    end
    reset = 1'b1;
    serial_in = d[4];
    step(1'b0, 1'b0, '0);
    reset = 1'b0;
    serial_in = 1'b0;
    n_cmp++;
    if ({channel_busy, valid, rx_active, overflow} !== 4'b0000 || parallel_out !== '0) begin
      n_err++;
      $display("FAIL midreset: busy=%b valid=%b act=%b ovf=%b out=%h, required all 0",
               channel_busy, valid, rx_active, overflow, parallel_out);
    end
    idle(2);
    rcv.delete();
    tx_frame(g);
    idle(1);
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    n_cmp++;
    if (rcv.size() != 1 || rcv[0] !== g || valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_next: pops=%0d valid=%b, required one pop of %h", rcv.size(), valid, g);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_flow_control();
    test_full_minus_one_ack();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
